// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared opcode and state encodings for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_mul
// Description : WIDTH-iteration unsigned shift-add multiplier. i_load latches
//               the operands and clears the accumulator; each i_step adds one
//               partial product. o_product already includes the current
//               step's contribution, so it is the full product while o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_product  = w_acc_next;
  assign o_done     = i_step && (r_cnt == CNT_W'(WIDTH - 1));

  // Operand latch, shifting multiplicand/multiplier and the step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Registered WIDTH-bit ALU with Start/Busy/Done handshake.
//               Add/logic ops complete in one cycle; MUL runs WIDTH cycles in
//               seq_alu_mul while the previous results stay on the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry;
  logic               r_overflow;
  logic               r_zero;
  logic               r_negative;

  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin;
  logic               w_is_arith;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_mul_load = (r_state == ST_IDLE) && Start && (Op == OP_MUL);
  assign w_mul_step = (r_state == ST_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (A),
    .i_b       (B),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // Single-cycle datapath: subtraction is A + ~B + carry-in, logic ops bypass the adder
  always_comb begin
    w_b_eff    = B;
    w_cin      = 1'b0;
    w_is_arith = 1'b1;
    case (Op)
      OP_ADD:  w_cin = 1'b0;
      OP_ADC:  w_cin = Cin;
      OP_SUB:  begin w_b_eff = ~B; w_cin = 1'b1; end
      OP_SBC:  begin w_b_eff = ~B; w_cin = Cin;  end
      default: w_is_arith = 1'b0;
    endcase
    w_sum = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    case (Op)
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      default: w_res = w_sum[WIDTH-1:0];
    endcase
    w_carry = w_is_arith && w_sum[WIDTH];
    w_ovf   = w_is_arith && (A[WIDTH-1] == w_b_eff[WIDTH-1])
                         && (w_sum[WIDTH-1] != A[WIDTH-1]);
  end

  // Control state machine with registered result, flag and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (Op == OP_MUL) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_result    <= w_res;
              r_result_hi <= '0;
              r_carry     <= w_carry;
              r_overflow  <= w_ovf;
              r_zero      <= (w_res == '0);
              r_negative  <= w_res[WIDTH-1];
              r_done      <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_result    <= w_mul_prod[WIDTH-1:0];
            r_result_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
            r_carry     <= |w_mul_prod[2*WIDTH-1:WIDTH];
            r_overflow  <= 1'b0;
            r_zero      <= (w_mul_prod == '0);
            r_negative  <= w_mul_prod[WIDTH-1];
            r_done      <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Result   = r_result;
  assign ResultHi = r_result_hi;
  assign Carry    = r_carry;
  assign Overflow = r_overflow;
  assign Zero     = r_zero;
  assign Negative = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=8): directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Busy, Done, Carry, Overflow, Zero, Negative;
  logic [W-1:0] Result, ResultHi;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int e_res, e_hi, e_c, e_v, e_z, e_n, e_done, e_busy;
  int m_left, m_a, m_b;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi),
    .Carry(Carry), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e_res = 0; e_hi = 0; e_c = 0; e_v = 0; e_z = 0; e_n = 0;
    e_done = 0; e_busy = 0; m_left = 0; m_a = 0; m_b = 0;
  endtask

  function automatic int to_signed(input int u);
    return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
  endfunction

  // What the outputs must become at this rising edge, from plain arithmetic
  task automatic model_edge();
    int ua, ub, sa, sb, ci, bw, u, s, prod;
    bit arith;
    if (!rst_n) begin
      model_reset();
    end else if (e_busy != 0) begin
      e_done = 0;
      m_left--;
      if (m_left == 0) begin
        prod   = m_a * m_b;
        e_res  = prod & MASK;
        e_hi   = (prod >> W) & MASK;
        e_c    = (e_hi != 0);
        e_v    = 0;
        e_z    = (prod == 0);
        e_n    = (e_res >> (W - 1)) & 1;
        e_done = 1;
        e_busy = 0;
      end
    end else if (Start) begin
      if (Op == 3'd7) begin
        m_a = int'(A); m_b = int'(B); m_left = W;
        e_busy = 1; e_done = 0;
      end else begin
        ua = int'(A); ub = int'(B); ci = int'(Cin);
        sa = to_signed(ua); sb = to_signed(ub);
        arith = 1; u = 0; s = 0; e_c = 0;
        case (Op)
          3'd0: begin u = ua + ub;      s = sa + sb;      e_c = (u > MASK); end
          3'd1: begin u = ua + ub + ci; s = sa + sb + ci; e_c = (u > MASK); end
          3'd2: begin u = ua - ub;      s = sa - sb;      e_c = (ua >= ub); end
          3'd3: begin
            bw = 1 - ci;
            u = ua - ub - bw; s = sa - sb - bw; e_c = (ua >= ub + bw);
          end
          3'd4: begin u = ua & ub; arith = 0; end
          3'd5: begin u = ua | ub; arith = 0; end
          default: begin u = ua ^ ub; arith = 0; end
        endcase
        e_res  = u & MASK;
        e_hi   = 0;
        e_v    = arith && ((s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1))));
        e_z    = (e_res == 0);
        e_n    = (e_res >> (W - 1)) & 1;
        e_done = 1;
      end
    end else begin
      e_done = 0;
    end
  endtask

  task automatic compare();
    chk("Busy",     Busy,     e_busy);
    chk("Done",     Done,     e_done);
    chk("Result",   Result,   e_res);
    chk("ResultHi", ResultHi, e_hi);
    chk("Carry",    Carry,    e_c);
    chk("Overflow", Overflow, e_v);
    chk("Zero",     Zero,     e_z);
    chk("Negative", Negative, e_n);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
    Start = 1'b1; Op = op; A = a; B = b; Cin = ci;
    tick();
    Start = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int bc;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_busy_lit",   Busy,   0);
    chk("reset_result_lit", Result, 0);
    rst_n = 1'b1;
    tick();

    // ADD 7F + 01: signed overflow into negative
    issue(3'd0, 8'h7F, 8'h01, 1'b0);
    chk("add_res_lit", Result, 8'h80);
    chk("add_v_lit",   Overflow, 1);
    chk("add_n_lit",   Negative, 1);
    chk("add_c_lit",   Carry, 0);
    chk("add_z_lit",   Zero, 0);
    chk("add_done_lit", Done, 1);
    tick();
    chk("add_done_drop_lit", Done, 0);

    issue(3'd2, 8'h05, 8'h05, 1'b0);
    chk("sub_eq_res_lit", Result, 8'h00);
    chk("sub_eq_z_lit",   Zero, 1);
    chk("sub_eq_c_lit",   Carry, 1);

    issue(3'd2, 8'h00, 8'h01, 1'b0);
    chk("sub_borrow_res_lit", Result, 8'hFF);
    chk("sub_borrow_c_lit",   Carry, 0);
    chk("sub_borrow_n_lit",   Negative, 1);
    chk("sub_borrow_v_lit",   Overflow, 0);

    issue(3'd1, 8'hFF, 8'h00, 1'b1);
    chk("adc_res_lit", Result, 8'h00);
    chk("adc_c_lit",   Carry, 1);
    chk("adc_z_lit",   Zero, 1);

    // MUL FF*FF with an ADD request attempted while busy
    issue(3'd7, 8'hFF, 8'hFF, 1'b0);
    bc = Busy ? 1 : 0;
    Start = 1'b1; Op = 3'd0; A = 8'h01; B = 8'h01;
    for (int i = 0; i < 20 && Busy; i++) begin
      tick();
      Start = 1'b0;
      if (Busy) bc++;
    end
    Start = 1'b0;
    chk("mul_busy_cycles_lit", bc, 8);
    chk("mul_done_lit", Done, 1);
    chk("mul_hi_lit",   ResultHi, 8'hFE);
    chk("mul_lo_lit",   Result, 8'h01);
    chk("mul_c_lit",    Carry, 1);
    tick();

    // MUL aborted by reset mid-operation
    issue(3'd7, 8'h0C, 8'h0A, 1'b0);
    tick(); tick(); tick();
    async_reset();
    chk("abort_done_lit",   Done, 0);
    chk("abort_result_lit", Result, 0);
    tick();

    issue(3'd7, 8'h0C, 8'h0A, 1'b0);
    A = 8'h55; B = 8'h33;
    repeat (W) tick();
    chk("mul2_lo_lit",   Result, 8'h78);
    chk("mul2_hi_lit",   ResultHi, 8'h00);
    chk("mul2_done_lit", Done, 1);

    // Randomized traffic, including back-to-back ops and occasional resets
    for (int i = 0; i < 600; i++) begin
      Start = ($urandom_range(0, 3) != 0);
      Op    = 3'($urandom_range(0, 7));
      A     = pick_operand();
      B     = pick_operand();
      Cin   = 1'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end
    Start = 1'b0;
    repeat (W + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised arithmetic/logic unit and the successor of the lab's 4-bit combinational add/subtract calculator. It is generalised to WIDTH bits and adds carry-chained add/subtract, bitwise ops and a multi-cycle unsigned shift-add multiplier. Every result and flag is registered. A Start/Busy/Done handshake lets a top-level controller or the board switch/LED wrapper sequence operations.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Asynchronous, active-low. Single clock domain.
- Start  in  1  request. Sampled only when Busy=0.
- Op  in  3  operation select: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MUL.
- A  in  WIDTH  operand A. Captured on the accepting edge.
- B  in  WIDTH  operand B. Captured on the accepting edge.
- Cin  in  1  carry-in for ADC/SBC. Ignored by other ops.
- Busy  out  1  high while a MUL is in progress.
- Done  out  1  one-cycle pulse: new Result and flags are valid.
- Result  out  WIDTH  result; for MUL, the low half of the product.
- ResultHi  out  WIDTH  high half of the MUL product. 0 for all other ops.
- Carry  out  1  carry-out (ADD/ADC), no-borrow (SUB/SBC), or ResultHi≠0 (MUL).
- Overflow  out  1  two's-complement overflow.
- Zero  out  1  result is zero.
- Negative  out  1  Result[WIDTH-1].

## Operation
- Reset value of every output is 0; the state machine resets to IDLE and the iteration counter to 0.
- States:
  - IDLE: Busy=0.
  - MUL: Busy=1.
- Transitions:
  - In IDLE with Start=1 and Op≠7: compute and register all outputs on that edge, stay in IDLE.
  - In IDLE with Start=1 and Op=7: latch A and B, clear the accumulator, go to MUL.
  - In MUL: one shift-add step per cycle. After WIDTH steps, register the outputs and return to IDLE.
- Arithmetic, computed at WIDTH+1 bits, with Carry as the MSB:
  - ADD: A+B.
  - ADC: A+B+Cin.
  - SUB: A+~B+1.
  - SBC: A+~B+Cin (Cin=1 means no borrow-in).
- Overflow for arithmetic ops, where B' is B for ADD/ADC and ~B for SUB/SBC: (A[W-1]==B'[W-1]) && (Result[W-1]!=A[W-1]).
- Logic ops: Carry=0, Overflow=0, ResultHi=0.
- MUL: unsigned product of A and B, giving {ResultHi,Result}. Overflow=0. Zero=1 only if the full 2·WIDTH-bit product is 0.
- Outputs hold their values between operations. Done is the only pulsed output.
- Start while Busy=1 is ignored: not queued, no effect.
- Operand changes during MUL have no effect, because the operands are latched.
- rst_n low mid-MUL aborts the operation immediately. No Done pulse is issued and all outputs are 0.

## Timing
- Single-cycle ops: the operation is accepted at edge N, and Result, flags and Done=1 are valid after edge N. Latency is 1 cycle.
- Back-to-back single-cycle ops: Start may stay high every cycle, giving one result per cycle with Done high continuously.
- MUL: accepted at edge N. Busy=1 from N through N+WIDTH-1. Outputs update and Done=1 after edge N+WIDTH, when Busy=0.
- A Start in the same cycle that MUL's Done is high is accepted, since Busy=0.
- While a MUL is in progress, Result and the flags keep the previous operation's values until the final edge.
- Done is high for exactly one cycle per accepted operation, except during back-to-back single-cycle ops.

## Structure
- Package seq_alu_pkg holds:
  - The Op encoding constants: OP_ADD through OP_MUL.
  - The state encoding: ST_IDLE, ST_MUL.
- Sub-module seq_alu_mul is the natural split. It is a WIDTH-iteration shift-add multiplier with load/step inputs and done/product outputs, instantiated once.
- The top level contains:
  - The state machine.
  - The combinational add/logic datapath.
  - The output registers and flag logic.

## Test plan
All scenarios use WIDTH=8.
- Reset: rst_n low, then release → all outputs 0, Busy=0.
- ADD A=0x7F, B=0x01 → one cycle later Result=0x80, Overflow=1, Negative=1, Carry=0, Zero=0, Done pulse.
- SUB A=0x05, B=0x05 → Result=0x00, Zero=1, Carry=1.
- SUB A=0x00, B=0x01 → Result=0xFF, Carry=0, Negative=1, Overflow=0.
- ADC A=0xFF, B=0x00, Cin=1 → Result=0x00, Carry=1, Zero=1.
- MUL A=0xFF, B=0xFF:
  - Busy high for 8 cycles.
  - Done after edge 8, with ResultHi=0xFE, Result=0x01, Carry=1.
  - A Start of ADD issued during Busy is ignored.
- MUL A=0x0C, B=0x0A with rst_n pulsed low at cycle 4 → outputs 0 immediately, no Done pulse.
- Then a new MUL with the same operands → Result=0x78, ResultHi=0x00.
